// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller in front of a word-only DataMem; sub-word stores are read-modify-write.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module lsu_mem_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int WORD_IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ADDR_W-1:0] dm_read_addr,
    output logic [31:0]       dm_write_data_rs2,
    output logic              dm_write_en,
    input  logic [31:0]       dm_read_data,
    output logic              ld_valid,
    output logic [31:0]       ld_data,
    output logic              misalign
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                state, state_next;
    logic [WORD_IDX_W-1:0] idx, idx_q;
    logic [31:0]           merge_q, merge_next;
    logic [31:0]           ld_ext;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic                  accept, legal, is_byte, is_half, is_word, mis;
    logic                  ld_accept, do_sub;
    logic                  unused_addr;

    // Index bits above the DataMem depth are deliberately ignored (address wraps).
    assign idx         = req_addr[WORD_IDX_W+1:2];
    assign unused_addr = ^req_addr[ADDR_W-1:WORD_IDX_W+2];
    assign accept      = req_valid && (state == IDLE);

    always_comb begin
        legal   = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        is_byte = legal && (req_funct3[1:0] == 2'b00);
        is_half = legal && (req_funct3[1:0] == 2'b01);
        is_word = legal && (req_funct3[1:0] == 2'b10);
`ifdef MISALIGN_TRAP_EN
        mis     = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
        mis     = 1'b0;
`endif
    end

    assign ld_accept = accept && !req_we && !mis;

    always_comb begin
        byte_lane = dm_read_data[{req_addr[1:0], 3'b000} +: 8];
        half_lane = dm_read_data[{req_addr[1], 4'b0000} +: 16];
        ld_ext    = 32'h0;
        case (req_funct3)
            3'b000:  ld_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  ld_ext = {24'h0, byte_lane};
            3'b001:  ld_ext = {{16{half_lane[15]}}, half_lane};
            3'b101:  ld_ext = {16'h0, half_lane};
            3'b010:  ld_ext = dm_read_data;
            default: ld_ext = 32'h0;
        endcase
    end

    always_comb begin
        merge_next = dm_read_data;
        if (is_byte)
            merge_next[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        else
            merge_next[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end

    // The write strobe is gated by rst_n so a pending merge is dropped when reset lands in WRITE.
    always_comb begin
        state_next        = state;
        req_ready         = 1'b0;
        dm_read_addr      = {{(ADDR_W-WORD_IDX_W){1'b0}}, idx};
        dm_write_data_rs2 = req_wdata;
        dm_write_en       = 1'b0;
        do_sub            = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && req_we && legal && !mis) begin
                    if (is_word) begin
                        dm_write_en = rst_n;
                    end else begin
                        do_sub     = 1'b1;
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                dm_read_addr      = {{(ADDR_W-WORD_IDX_W){1'b0}}, idx_q};
                dm_write_data_rs2 = merge_q;
                dm_write_en       = rst_n;
                state_next        = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            merge_q  <= 32'h0;
            idx_q    <= '0;
            ld_valid <= 1'b0;
            ld_data  <= 32'h0;
            misalign <= 1'b0;
        end else begin
            state    <= state_next;
            ld_valid <= ld_accept;
            misalign <= accept && mis;
            if (do_sub) begin
                merge_q <= merge_next;
                idx_q   <= idx;
            end
            if (ld_accept)
                ld_data <= ld_ext;
        end
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store controller in the MEM stage, directly upstream of DataMem. It accepts one memory request per cycle from the EX/MEM pipeline register and converts the byte address to a DataMem word index. It performs byte and halfword stores as a two-cycle read-modify-write, because DataMem only writes whole words. Load data is extracted, sign- or zero-extended, and returned registered toward the MEM/WB register.

Parameters:
ADDR_W, 32, width of the request byte address and of dm_read_addr
WORD_IDX_W, 6, DataMem word-index width (64 words)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present from EX/MEM
req_ready  output  1  request accepted this cycle when req_valid & req_ready
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data (rs2)
dm_read_addr  output  ADDR_W  word index to DataMem, zero-extended; bits above WORD_IDX_W are 0
dm_write_data_rs2  output  32  full word to write
dm_write_en  output  1  DataMem write strobe
dm_read_data  input  32  DataMem combinational read word
ld_valid  output  1  registered load-result strobe
ld_data  output  32  registered extended load result
misalign  output  1  registered misaligned-access flag

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state IDLE; ld_valid=0, ld_data=0, misalign=0, merge_q=0, idx_q=0.
  - dm_write_en is gated by rst_n, so it is 0 in any cycle with rst_n=0.
- Word index: idx = req_addr[WORD_IDX_W+1:2].
- States: IDLE and WRITE. req_ready=1 only in IDLE.
- IDLE, load accepted:
  - dm_read_addr = idx.
  - Next cycle: ld_valid=1 and ld_data = lane extracted from this cycle's dm_read_data.
  - B/BU select byte addr[1:0]; H/HU select halfword addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
  - Latency 1; back-to-back loads run at full throughput.
- IDLE, SW accepted: dm_write_en=1 the same cycle with dm_write_data_rs2=req_wdata; state stays IDLE; no stall.
- IDLE, SB/SH accepted:
  - Read idx combinationally.
  - Register merge_q = dm_read_data with the selected lane replaced by req_wdata[7:0] or req_wdata[15:0]; register idx_q = idx.
  - Go to WRITE. dm_write_en=0 this cycle.
- WRITE:
  - dm_read_addr=idx_q, dm_write_data_rs2=merge_q, dm_write_en=1, req_ready=0.
  - Any req_valid is held by upstream and not accepted.
  - Next state IDLE. Total store-sub-word cost: 2 cycles, 1 stall cycle.
- ld_valid and misalign are single-cycle pulses; ld_data holds its last value otherwise.
- Illegal funct3 (011, 110, 111): request is consumed. A load returns ld_valid=1 with ld_data=0; a store does not write.
- No request (req_valid=0) in IDLE: dm_write_en=0, dm_read_addr=idx of req_addr (don't-care read).
- Reset in WRITE: pending merged write is dropped (no DataMem write); state goes to IDLE.
- Address wrap: index bits above WORD_IDX_W+1 are ignored, so 0x100 aliases 0x000.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: misaligned accesses are rejected.
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00.
  - The request is consumed with no write, ld_valid stays 0, and misalign=1 the next cycle.
- Not defined: misalign is tied 0; offset bits below the access size are ignored (halfword uses addr[1], word uses the word index only).

Test Plan:
- Reset then LW addr 0x10 (DataMem word 4 = 0x00000008) -> next cycle ld_valid=1, ld_data=0x00000008; dm_read_addr=4.
- SB wdata 0x000000AB at 0x11 on word 0x00000008 -> req_ready=0 for 1 cycle, then dm_write_en=1 with data 0x0000AB08 at index 4; then LB 0x11 -> 0xFFFFFFAB, LBU 0x11 -> 0x000000AB.
- SH 0x0000BEEF at 0x22 -> word 8 = 0xBEEF0008; LH 0x22 -> 0xFFFFBEEF; LHU 0x22 -> 0x0000BEEF; LW 0x20 -> 0xBEEF0008.
- SW 0x12345678 at 0x04, followed by LW 0x04 the next cycle -> write the same cycle as acceptance, no stall; ld_data=0x12345678 one cycle after the load.
- SB at 0x30, rst_n=0 during the WRITE cycle -> dm_write_en=0; word 12 still 0x00000008; req_ready=1 after reset.
- LW 0x13 with MISALIGN_TRAP_EN -> misalign=1, ld_valid=0, no write. Without the macro -> ld_valid=1, ld_data=word 4.
